// File: rtl/bs_nal_packer.sv
// Annex-B NAL packer: start code + header, emulation prevention, last tagging, output FIFO.
// Optional nal_len/nal_done byte counter enabled by defining BS_NAL_LEN_EN.
module bs_nal_packer #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [7:0]  nal_header,
    input  logic        frame_end,
    input  logic        bs_valid,
    input  logic [7:0]  bs_o,
    output logic        nal_valid,
    output logic [7:0]  nal_data,
    output logic        nal_last,
    input  logic        nal_ready,
    output logic        busy,
    output logic        ovf_err,
    output logic [23:0] nal_len,
    output logic        nal_done
);
    // state | meaning
    // IDLE  | waiting for frame_start
    // HDR   | writing 00 00 00 01 + nal_header, one byte per cycle
    // BODY  | RBSP bytes through hold register with emulation prevention
    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    state_t      state;
    logic [2:0]  hdr_idx;
    logic [7:0]  hdr_q;
    logic        hold_valid;
    logic [7:0]  hold_data;
    logic        end_pend;
    logic [1:0]  zero_cnt;

    logic [8:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] count, free;
    logic [AW-1:0] wr_idx0, wr_idx1;

    logic        commit_en, commit_last, epb;
    logic [7:0]  commit_byte, hdr_byte;
    logic [1:0]  n_wr;
    logic [8:0]  wr0_data, wr1_data;
    logic        wr_ok, wr_drop, rd_en, ovf_set, ovf_clr;

    assign count   = wr_ptr - rd_ptr;
    assign free    = (AW+1)'(DEPTH) - count;
    assign wr_idx0 = wr_ptr[AW-1:0];
    assign wr_idx1 = wr_ptr[AW-1:0] + AW'(1);

    always_comb begin
        commit_en   = 1'b0;
        commit_last = 1'b0;
        commit_byte = hold_data;
        if (state == BODY && hold_valid) begin
            if (bs_valid) begin
                commit_en = 1'b1;
            end else if (end_pend) begin
                commit_en   = 1'b1;
                commit_last = 1'b1;
            end
        end
    end

    always_comb begin
        case (hdr_idx)
            3'd0, 3'd1, 3'd2: hdr_byte = 8'h00;
            3'd3:             hdr_byte = 8'h01;
            default:          hdr_byte = hdr_q;
        endcase
    end

    assign epb = commit_en && (zero_cnt == 2'd2) && (commit_byte <= 8'h03);

    always_comb begin
        n_wr     = 2'd0;
        wr0_data = {1'b0, hdr_byte};
        wr1_data = {commit_last, commit_byte};
        if (state == HDR) begin
            n_wr = 2'd1;
        end else if (commit_en) begin
            n_wr     = epb ? 2'd2 : 2'd1;
            wr0_data = epb ? 9'h003 : {commit_last, commit_byte};
        end
    end

    // A write group that does not fit is dropped whole, including its last tag.
    assign wr_ok   = (n_wr != 2'd0) && (free >= (AW+1)'(n_wr));
    assign wr_drop = (n_wr != 2'd0) && !wr_ok;
    assign rd_en   = (count != '0) && (!nal_valid || nal_ready);
    assign ovf_set = wr_drop || (bs_valid && state != BODY) || (frame_start && state != IDLE);
    assign ovf_clr = frame_start && state == IDLE;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx0] <= wr0_data;
            if (n_wr == 2'd2) mem[wr_idx1] <= wr1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hdr_idx    <= '0;
            hdr_q      <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            end_pend   <= 1'b0;
            zero_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            nal_valid  <= 1'b0;
            nal_data   <= '0;
            nal_last   <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            if (ovf_set)      ovf_err <= 1'b1;
            else if (ovf_clr) ovf_err <= 1'b0;

            if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(n_wr);

            if (rd_en) begin
                nal_valid <= 1'b1;
                {nal_last, nal_data} <= mem[rd_ptr[AW-1:0]];
                rd_ptr    <= rd_ptr + 1'b1;
            end else if (nal_ready) begin
                nal_valid <= 1'b0;
            end

            if (commit_en) begin
                if (epb)
                    zero_cnt <= (commit_byte == 8'h00) ? 2'd1 : 2'd0;
                else if (commit_byte == 8'h00)
                    zero_cnt <= (zero_cnt == 2'd2) ? 2'd2 : zero_cnt + 2'd1;
                else
                    zero_cnt <= 2'd0;
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state   <= HDR;
                        hdr_idx <= '0;
                        hdr_q   <= nal_header;
                    end
                end
                HDR: begin
                    hdr_idx <= hdr_idx + 3'd1;
                    if (hdr_idx == 3'd4) begin
                        state      <= BODY;
                        zero_cnt   <= '0;
                        end_pend   <= 1'b0;
                        hold_valid <= 1'b0;
                    end
                end
                BODY: begin
                    if (frame_end) end_pend <= 1'b1;
                    if (bs_valid) begin
                        hold_data  <= bs_o;
                        hold_valid <= 1'b1;
                    end else if (end_pend) begin
                        hold_valid <= 1'b0;
                        end_pend   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE) || (count != '0) || nal_valid || hold_valid;

`ifdef BS_NAL_LEN_EN
    logic [23:0] len_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt  <= '0;
            nal_len  <= '0;
            nal_done <= 1'b0;
        end else begin
            nal_done <= 1'b0;
            if (nal_valid && nal_ready) begin
                if (nal_last) begin
                    nal_len  <= len_cnt + 24'd1;
                    nal_done <= 1'b1;
                    len_cnt  <= '0;
                end else begin
                    len_cnt <= len_cnt + 24'd1;
                end
            end
        end
    end
`else
    assign nal_len  = '0;
    assign nal_done = 1'b0;
`endif

endmodule

// File: tb/tb_bs_nal_packer.sv
// Directed bench for bs_nal_packer (DEPTH=16) with an expected-byte queue.
module tb_bs_nal_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start, frame_end, bs_valid, nal_ready;
    logic [7:0]  nal_header, bs_o;
    logic        nal_valid, nal_last, busy, ovf_err, nal_done;
    logic [7:0]  nal_data;
    logic [23:0] nal_len;

    bs_nal_packer #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .nal_header(nal_header),
        .frame_end(frame_end), .bs_valid(bs_valid), .bs_o(bs_o),
        .nal_valid(nal_valid), .nal_data(nal_data), .nal_last(nal_last), .nal_ready(nal_ready),
        .busy(busy), .ovf_err(ovf_err), .nal_len(nal_len), .nal_done(nal_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_len = 0;
    int len_carry = 0;
    int done_cnt = 0;
    bit toggle_mode = 0;
    bit mon_en = 1;
    bit stall_prev = 0;
    logic [7:0] sd;
    logic       sl;
    logic [8:0] exp_q [$];
    logic [7:0] rbsp [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [8:0] v);
        exp_q.push_back(v);
        exp_len++;
    endtask

    // Reference: start code + header, then RBSP with 0x03 inserted after two zeros before bytes <= 3.
    task automatic push_expect(input logic [7:0] hdr, input int keep);
        int zc;
        logic [7:0] b;
        logic last;
        exp_len = 0;
        push(9'h000); push(9'h000); push(9'h000); push(9'h001); push({1'b0, hdr});
        zc = 0;
        for (int i = 0; i < keep; i++) begin
            b = rbsp[i];
            last = (keep == rbsp.size()) && (i == rbsp.size() - 1);
            if (zc >= 2 && b <= 8'h03) begin
                push(9'h003);
                zc = (b == 8'h00) ? 1 : 0;
            end else begin
                zc = (b == 8'h00) ? ((zc < 2) ? zc + 1 : 2) : 0;
            end
            push({last, b});
        end
    endtask

    task automatic cycle();
        logic [8:0] e;
        @(negedge clk);
        if (mon_en && nal_valid && nal_ready) begin
            if (exp_q.size() == 0) chk("extra_byte", 32'(exp_q.size()), 32'd1);
            else begin
                e = exp_q.pop_front();
                chk("nal_byte", 32'({nal_last, nal_data}), 32'(e));
            end
        end
        if (mon_en && stall_prev)
            chk("stall_hold", 32'({nal_valid, nal_last, nal_data}), 32'({1'b1, sl, sd}));
        stall_prev = nal_valid && !nal_ready;
        sd = nal_data;
        sl = nal_last;
        if (nal_done) done_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (toggle_mode) nal_ready = (cyc % 3 == 0);
    endtask

    task automatic run_frame(input logic [7:0] hdr, input int gap, input bit end_sep,
                             input bit lat, input int keep);
        done_cnt = 0;
        push_expect(hdr, keep);
        frame_start = 1'b1;
        nal_header = hdr;
        cycle();
        frame_start = 1'b0;
        chk("ovf_clr_on_start", 32'(ovf_err), 32'd0);
        if (lat) begin
            cycle();
            chk("lat_t1_valid", 32'(nal_valid), 32'd0);
            cycle();
            chk("lat_t2_valid_data", 32'({nal_valid, nal_data}), 32'h100);
            repeat (3) cycle();
        end else begin
            repeat (5) cycle();
        end
        for (int i = 0; i < rbsp.size(); i++) begin
            bs_valid = 1'b1;
            bs_o = rbsp[i];
            frame_end = (i == rbsp.size() - 1) && !end_sep;
            cycle();
            bs_valid = 1'b0;
            frame_end = 1'b0;
            repeat (gap) cycle();
        end
        if (end_sep) begin
            frame_end = 1'b1;
            cycle();
            frame_end = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            cycle();
            t++;
        end
        chk("drain_in_time", 32'(t < 3000), 32'd1);
        repeat (2) cycle();
    endtask

    task automatic finish_frame();
        drain();
        chk("ovf_clean", 32'(ovf_err), 32'd0);
`ifdef BS_NAL_LEN_EN
        chk("nal_len", 32'(nal_len), 32'(len_carry + exp_len));
        chk("nal_done_pulses", 32'(done_cnt), 32'd1);
`else
        chk("nal_len_zero", 32'(nal_len), 32'd0);
        chk("nal_done_none", 32'(done_cnt), 32'd0);
`endif
        len_carry = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        frame_start = 0; frame_end = 0; bs_valid = 0; nal_ready = 1;
        nal_header = 0; bs_o = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        chk("rst_outputs", 32'({nal_valid, nal_last, nal_data, busy, ovf_err, nal_done}), 32'd0);
        chk("rst_len", 32'(nal_len), 32'd0);

        bs_valid = 1'b1; bs_o = 8'h55;
        cycle();
        bs_valid = 1'b0;
        chk("idle_byte_ovf", 32'(ovf_err), 32'd1);
        chk("idle_byte_not_busy", 32'(busy), 32'd0);

        rbsp = '{8'h11, 8'h22, 8'h80};
        run_frame(8'h65, 0, 0, 1, 3);
        finish_frame();

        rbsp = '{8'h00, 8'h00, 8'h01, 8'h80};
        run_frame(8'h41, 1, 1, 0, 4);
        finish_frame();

        rbsp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        run_frame(8'h01, 0, 0, 0, 5);
        finish_frame();

        rbsp = '{8'h00, 8'h00, 8'h04};
        run_frame(8'h01, 2, 0, 0, 3);
        finish_frame();

        rbsp = '{8'h00, 8'h00, 8'h03};
        run_frame(8'h25, 0, 1, 0, 3);
        finish_frame();

        rbsp.delete();
        for (int i = 0; i < 20; i++)
            rbsp.push_back((i % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255)));
        toggle_mode = 1;
        run_frame(8'h21, 7, 0, 0, 20);
        finish_frame();
        toggle_mode = 0;
        nal_ready = 1'b1;

        // Overflow: output stalled, 30 bytes into a 16-entry FIFO.
        nal_ready = 1'b0;
        rbsp.delete();
        for (int i = 0; i < 30; i++) rbsp.push_back(8'h10 + 8'(i));
        done_cnt = 0;
        run_frame(8'h06, 0, 0, 0, 12);
        repeat (5) cycle();
        chk("ovf_set_full", 32'(ovf_err), 32'd1);
        chk("ovf_nothing_out", 32'(exp_q.size()), 32'd17);
        nal_ready = 1'b1;
        drain();
        chk("ovf_no_done", 32'(done_cnt), 32'd0);
        len_carry = 17;

        rbsp = '{8'h11, 8'h22, 8'h80};
        run_frame(8'h65, 0, 0, 0, 3);
        finish_frame();

        // Reset in the middle of a body, with ovf_err set by a stray frame_start.
        mon_en = 0;
        frame_start = 1'b1; nal_header = 8'h65;
        cycle();
        frame_start = 1'b0;
        repeat (5) cycle();
        bs_valid = 1'b1; bs_o = 8'h11; cycle();
        bs_o = 8'h22; cycle();
        bs_valid = 1'b0;
        frame_start = 1'b1; cycle();
        frame_start = 1'b0;
        chk("start_in_body_ovf", 32'(ovf_err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 32'({nal_valid, busy, ovf_err}), 32'd0);
        exp_q.delete();
        stall_prev = 0;
        len_carry = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1;
        cycle();

        rbsp = '{8'h11, 8'h22, 8'h80};
        run_frame(8'h65, 0, 0, 1, 3);
        finish_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bs_nal_packer.md
Name: bs_nal_packer

Overview:
- Sits directly downstream of the byte-stream FIFO, consuming its byte stream (bs_valid / bs_o); bs_valid has no backpressure.
- Wraps each frame's RBSP bytes into an Annex-B NAL unit:
  - prepends start code 00 00 00 01 plus a NAL header byte;
  - inserts emulation-prevention bytes (0x03);
  - tags the final byte.
- Buffers the result in an internal FIFO and presents it on a valid/ready byte interface toward the AXI write-out stage.

Parameters:
DEPTH, 64, FIFO entries (power of two, >=16); each entry 9 bits = {last, data[7:0]}
AW, 6, log2(DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
frame_start  in  1  pulse: begin NAL; latches nal_header
nal_header  in  8  NAL header byte (forbidden_zero/nal_ref_idc/nal_unit_type)
frame_end  in  1  pulse: last RBSP byte has been delivered (or arrives this cycle)
bs_valid  in  1  input byte strobe, no backpressure
bs_o  in  8  input RBSP byte
nal_valid  out  1  output byte valid
nal_data  out  8  output byte
nal_last  out  1  final byte of NAL
nal_ready  in  1  downstream accept
busy  out  1  state != IDLE or FIFO/output register non-empty
ovf_err  out  1  sticky error; cleared by an accepted frame_start
nal_len  out  24  byte count of last completed NAL (optional feature)
nal_done  out  1  1-cycle pulse when the nal_last byte is accepted (optional feature)

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; hold register empty; zero_cnt=0.
- States:
  - IDLE: frame_start -> HDR, hdr_idx=0. bs_valid in IDLE: byte dropped, ovf_err=1.
  - HDR: 5 cycles, one FIFO write per cycle: 00, 00, 00, 01, nal_header (last=0). No EPB on header; zero_cnt=0 on exit. -> BODY.
    - bs_valid during HDR: byte dropped, ovf_err=1 (contract: first bs_valid >=6 cycles after frame_start).
  - BODY:
    - Incoming byte goes to a 1-byte hold register.
    - When a new byte arrives with hold valid, the held byte is committed to the FIFO.
    - frame_end sets end_pend.
    - First cycle with end_pend and no bs_valid: commit held byte with last=1, clear end_pend -> IDLE.
    - frame_end coincident with bs_valid: that byte becomes the last byte.
- Commit / EPB rule:
  - If zero_cnt>=2 and byte<=0x03: write 0x03 then byte (2 writes, consecutive addresses, same cycle); zero_cnt = (byte==0)?1:0.
  - Otherwise write byte; zero_cnt = (byte==0)?min(zero_cnt+1,2):0.
- frame_start while not IDLE: ignored, ovf_err=1.
- frame_end in IDLE/HDR: ignored.
- FIFO:
  - Up to 2 writes and 1 read per cycle.
  - Pointers AW+1 bits, wrap naturally; count = wr-rd.
  - A write group that does not fit in the free space is dropped whole, ovf_err=1, pointers unchanged. The last tag is lost too; the flush still returns to IDLE.
- Output:
  - Registered. Output reg is loaded from the FIFO when empty, or when (nal_valid & nal_ready).
  - nal_data/nal_last are held stable while nal_valid & !nal_ready.
  - Throughput 1 byte/cycle.
- Latency:
  - frame_start at cycle t -> nal_valid=1 with 0x00 at t+2 (nal_ready=1).
  - RBSP byte is visible 2 cycles after commit.
- busy falls the cycle after the nal_last handshake if nothing is pending.

Optional Feature:
- BS_NAL_LEN_EN defined:
  - 24-bit counter increments on each accepted output byte (header + EPB bytes included).
  - On nal_last handshake: nal_len <= count+1, nal_done pulses next cycle, counter clears.
- Undefined: nal_len=0 and nal_done=0 constant; counter not built.

Test Plan:
- frame_start, hdr 0x65, bytes 11 22 80, frame_end, ready=1 -> nal_data 00 00 00 01 65 11 22 80, last on 0x80; nal_len=8 (with BS_NAL_LEN_EN).
- RBSP 00 00 01 80 -> 00 00 03 01 80 after header; nal_len=10.
- RBSP 00 00 00 00 80 -> 00 00 03 00 00 80; 00 00 04 -> 00 00 04 (no EPB).
- nal_ready toggling 1-of-3 cycles during a 20-byte NAL -> data stable while stalled, order intact, no loss, ovf_err=0.
- DEPTH=16, nal_ready=0, 30 input bytes -> FIFO fills, excess dropped, ovf_err=1; next frame_start clears ovf_err.
- rst_n asserted mid-BODY -> nal_valid=0, busy=0, ovf_err=0 immediately; a new frame after release produces a clean start code.
